// File: rtl/multiword_adder_pkg.sv
// Shared FSM state encoding and the word-index width helper for the multiword adder.
package multiword_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_width(input int nbwords);
    return (nbwords <= 1) ? 1 : $clog2(nbwords);
  endfunction

endpackage

// File: rtl/adder.sv
// Combinational word adder with carry in/out; zero latency, no flow control.
module adder #(
  parameter int DATASIZE = 8
) (
  input  logic [DATASIZE-1:0] a_i,
  input  logic [DATASIZE-1:0] b_i,
  input  logic                carryin_i,
  output logic [DATASIZE-1:0] result_o,
  output logic                carryout_o
);

  assign {carryout_o, result_o} = {1'b0, a_i} + {1'b0, b_i} + {{DATASIZE{1'b0}}, carryin_i};

endmodule

// File: rtl/multiword_adder_seq.sv
// Adds two NBWORDS-word operands one word per cycle through an external adder; NBWORDS cycles accept->valid.
// Accepts only when idle; holds result/carry in DONE until out_ready_i, one op per NBWORDS+2 cycles.
module multiword_adder_seq
  import multiword_adder_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int NBWORDS  = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [DATASIZE*NBWORDS-1:0]  op_a_i,
  input  logic [DATASIZE*NBWORDS-1:0]  op_b_i,
  input  logic                         carry_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [DATASIZE*NBWORDS-1:0]  result_o,
  output logic                         carry_o,
  output logic [DATASIZE-1:0]          adder_a_o,
  output logic [DATASIZE-1:0]          adder_b_o,
  output logic                         adder_carry_o,
  input  logic [DATASIZE-1:0]          adder_result_i,
  input  logic                         adder_carry_i
);

  localparam int             IW   = idx_width(NBWORDS);
  localparam logic [IW-1:0]  LAST = IW'(NBWORDS - 1);

  state_t                            state;
  logic [IW-1:0]                     idx;
  logic [NBWORDS-1:0][DATASIZE-1:0]  op_a_q;
  logic [NBWORDS-1:0][DATASIZE-1:0]  op_b_q;
  logic [NBWORDS-1:0][DATASIZE-1:0]  res_q;
  logic                              carry_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      idx     <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            op_a_q  <= op_a_i;
            op_b_q  <= op_b_i;
            carry_q <= carry_i;
            idx     <= '0;
            state   <= ADD;
          end
        end
        ADD: begin
          // The carry register doubles as the ripple link between successive words.
          res_q[idx] <= adder_result_i;
          carry_q    <= adder_carry_i;
          if (idx == LAST) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready_o    = (state == IDLE);
  assign out_valid_o   = (state == DONE);
  assign result_o      = res_q;
  assign carry_o       = carry_q;

  // Adder drive decodes only registered state, so nothing from in_* reaches the adder combinationally.
  assign adder_a_o     = (state == ADD) ? op_a_q[idx] : '0;
  assign adder_b_o     = (state == ADD) ? op_b_q[idx] : '0;
  assign adder_carry_o = (state == ADD) ? carry_q     : 1'b0;

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Directed and random checks of multiword_adder_seq against plain A+B+cin arithmetic.
module tb_multiword_adder_seq;

  localparam int DATASIZE = 8;
  localparam int NBWORDS  = 4;
  localparam int W        = DATASIZE * NBWORDS;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [W-1:0]        op_a;
  logic [W-1:0]        op_b;
  logic                carry_in;
  logic                out_valid;
  logic                out_ready;
  logic [W-1:0]        result;
  logic                carry_out;
  logic [DATASIZE-1:0] ad_a;
  logic [DATASIZE-1:0] ad_b;
  logic                ad_c;
  logic [DATASIZE-1:0] ad_res;
  logic                ad_co;

  int errors = 0;
  int checks = 0;
  int results_seen = 0;

  always #5 clk = ~clk;

  multiword_adder_seq #(.DATASIZE(DATASIZE), .NBWORDS(NBWORDS)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .op_a_i        (op_a),
    .op_b_i        (op_b),
    .carry_i       (carry_in),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .result_o      (result),
    .carry_o       (carry_out),
    .adder_a_o     (ad_a),
    .adder_b_o     (ad_b),
    .adder_carry_o (ad_c),
    .adder_result_i(ad_res),
    .adder_carry_i (ad_co)
  );

  adder #(.DATASIZE(DATASIZE)) u_adder (
    .a_i       (ad_a),
    .b_i       (ad_b),
    .carryin_i (ad_c),
    .result_o  (ad_res),
    .carryout_o(ad_co)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one operand set; returns at the negedge just after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int wait_cyc = 0;
    @(negedge clk);
    while (!in_ready && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    op_a     = a;
    op_b     = b;
    carry_in = c;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    op_a     = W'($urandom);
    op_b     = W'($urandom);
    carry_in = 1'($urandom);
  endtask

  // Wait for the result, stall 'stall' cycles with junk in_valid pulses, then hand it off.
  task automatic finish_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                           input int stall, input string tag);
    logic [W:0] exp_sum;
    int lat = 0;
    exp_sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(NBWORDS));
    for (int s = 0; s < stall; s++) begin
      chk({tag, "_stall_valid"}, {63'd0, out_valid}, 64'd1);
      chk({tag, "_stall_in_ready"}, {63'd0, in_ready}, 64'd0);
      chk({tag, "_stall_result"}, 64'(result), 64'(exp_sum[W-1:0]));
      in_valid = s[0];
      op_a     = W'($urandom);
      op_b     = W'($urandom);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_result"}, 64'(result), 64'(exp_sum[W-1:0]));
    chk({tag, "_carry"}, {63'd0, carry_out}, {63'd0, exp_sum[W]});
    out_ready = 1'b1;
    if (out_valid) results_seen++;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_post_in_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input int stall, input string tag);
    start_op(a, b, c);
    finish_op(a, b, c, stall, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    carry_in  = 1'b0;
    #12;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_carry", {63'd0, carry_out}, 64'd0);
    chk("rst_adder_a", 64'(ad_a), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0, "ff_plus_1");
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, "ripple_all");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0, "msb_carry");
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 0, "mixed");
    run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 3, "stall3");
    run_op(32'h0000_0001, 32'h0000_0002, 1'b0, 0, "after_stall");

    // Asynchronous reset in the middle of an operation, while word 2 is on the adder.
    start_op(32'h0102_0304, 32'h0506_0708, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_adder_a_word2", 64'(ad_a), 64'h02);
    chk("mid_adder_b_word2", 64'(ad_b), 64'h06);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_result", 64'(result), 64'd0);
    chk("arst_carry", {63'd0, carry_out}, 64'd0);
    chk("arst_adder_a", 64'(ad_a), 64'd0);
    chk("arst_adder_b", 64'(ad_b), 64'd0);
    chk("arst_adder_c", {63'd0, ad_c}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h0101_0101, 32'h0101_0101, 1'b0, 0, "post_reset");

    results_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 7))
        0:       begin ra = '1; rb = W'($urandom); end
        1:       begin ra = W'($urandom); rb = '0; end
        default: begin ra = W'($urandom); rb = W'($urandom); end
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), "rand");
    end
    chk("rand_result_count", 64'(results_seen), 64'd1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
